// File: rtl/iter_divider_pkg.sv
// ---------------------------------------------------------------------------
// iter_divider_pkg
//   Shared definitions for the E-stage iterative divider.
//   Contents:
//     DIV_WIDTH    default operand/result width
//     DIV_CNT_W    default iteration-counter width (clog2 of DIV_WIDTH)
//     div_state_t  divider FSM state encoding
// ---------------------------------------------------------------------------
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  // IDLE waits for a DIV/DIVU, BUSY iterates one quotient bit per clock,
  // DONE presents the result until the instruction leaves E.
  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/iter_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring shift-subtract slice.
//   Ports:
//     rem_in     [WIDTH-1:0]  partial remainder before this step
//     q_bit_in                next dividend bit shifted into the remainder
//     divisor    [WIDTH-1:0]  divisor magnitude
//     rem_out    [WIDTH-1:0]  partial remainder after this step
//     q_bit_out               quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             q_bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit_out
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;

  // The shifted remainder is kept one bit wider than the operands: with an
  // unsigned divisor above 2^(WIDTH-1) the shift can carry out of WIDTH bits,
  // and dropping that carry would give a wrong compare. After a successful
  // subtract the result always fits back into WIDTH bits.
  always_comb begin
    rem_shift = {rem_in, q_bit_in};
    rem_diff  = rem_shift - {1'b0, divisor};
    q_bit_out = (rem_shift >= {1'b0, divisor});
    rem_out   = q_bit_out ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
//   Produces quotient on div_lo and remainder on div_hi; div_ready tells the
//   hazard unit when the result is valid so it can release the stall.
//   Ports:
//     clk         pipeline clock
//     resetn      synchronous active-low reset
//     div_en      E-stage instruction is DIV/DIVU
//     div_sign    1 = signed (DIV), 0 = unsigned (DIVU)
//     div_a       dividend
//     div_b       divisor
//     cancel      E-stage flush, aborts any operation
//     pipe_stall  E-stage stall, keeps a finished result presented
//     div_ready   result valid
//     div_busy    iteration in progress
//     div_hi      remainder
//     div_lo      quotient
// ---------------------------------------------------------------------------
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_en,
  input  logic             div_sign,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  input  logic             cancel,
  input  logic             pipe_stall,
  output logic             div_ready,
  output logic             div_busy,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;
  logic [WIDTH-1:0] quo_next;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // remainder each step while the new quotient bit enters at the LSB, so
  // after WIDTH steps it holds the unsigned quotient.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in   (rem_q),
    .q_bit_in (quo_q[WIDTH-1]),
    .divisor  (dvsr_q),
    .rem_out  (step_rem),
    .q_bit_out(step_q_bit)
  );

  // Operand magnitudes; only DIV treats the MSB as a sign. Negating the most
  // negative value yields itself, which is the correct unsigned magnitude.
  always_comb begin
    a_abs    = (div_sign && div_a[WIDTH-1]) ? (~div_a + 1'b1) : div_a;
    b_abs    = (div_sign && div_b[WIDTH-1]) ? (~div_b + 1'b1) : div_b;
    quo_next = {quo_q[WIDTH-2:0], step_q_bit};
  end

  // Next-state and datapath control. A flush wins over everything and
  // leaves hi/lo untouched so a squashed divide never disturbs the last
  // architectural result.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (cancel) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_en) begin
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            neg_quo_d = div_sign & (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
            neg_rem_d = div_sign & div_a[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = DIV_BUSY;
          end
        end

        DIV_BUSY: begin
          rem_d = step_rem;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            lo_d    = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
            hi_d    = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
            state_d = DIV_DONE;
          end
        end

        DIV_DONE: begin
          // A stalled pipeline keeps the same instruction in E; it must see
          // its result again rather than restart.
          if (!pipe_stall) begin
            state_d = DIV_IDLE;
          end
        end

        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset; reset also drops
  // any partially computed result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Status flags decode straight from the state register, so div_ready is
  // low in the issue cycle and the hazard unit stalls immediately.
  always_comb begin
    div_ready = (state_q == DIV_DONE);
    div_busy  = (state_q == DIV_BUSY);
    div_hi    = hi_q;
    div_lo    = lo_q;
  end

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//   Self-checking bench for iter_divider: a table of divide vectors run
//   through a scoreboard queue, plus hand-written hold, back-to-back,
//   cancel and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_iter_divider;

  localparam int W       = 32;
  localparam int LATENCY = 33;
  localparam int TIMEOUT = 40;

  logic         clk;
  logic         resetn;
  logic         div_en;
  logic         div_sign;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         cancel;
  logic         pipe_stall;
  logic         div_ready;
  logic         div_busy;
  logic [W-1:0] div_hi;
  logic [W-1:0] div_lo;

  typedef struct {
    string        name;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   n_compared;
  int   n_mismatched;

  iter_divider #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_en    (div_en),
    .div_sign  (div_sign),
    .div_a     (div_a),
    .div_b     (div_b),
    .cancel    (cancel),
    .pipe_stall(pipe_stall),
    .div_ready (div_ready),
    .div_busy  (div_busy),
    .div_hi    (div_hi),
    .div_lo    (div_lo)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence wedges outside its own bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a line on mismatch.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  // Drive a divide at the current negedge and log its expected result.
  task automatic applyStimulus(input logic sign, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] lo,
                               input logic [W-1:0] hi);
    exp_t e;
    div_en   = 1'b1;
    div_sign = sign;
    div_a    = a;
    div_b    = b;
    e.lo     = lo;
    e.hi     = hi;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for div_ready, then check latency and pop the scoreboard.
  task automatic waitResult(input string name);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput({name, "_busy"}, W'(div_busy), W'(1));
    end while (!div_ready && cyc < TIMEOUT);
    checkOutput({name, "_latency"}, W'(cyc), W'(LATENCY));
    if (sb_q.size() == 0) begin
      checkOutput({name, "_sb_empty"}, W'(0), W'(1));
    end else begin
      e = sb_q.pop_front();
      checkOutput({name, "_lo"}, div_lo, e.lo);
      checkOutput({name, "_hi"}, div_hi, e.hi);
    end
  endtask

  // Let the finished instruction leave E; returns at a negedge in IDLE.
  task automatic releaseResult();
    div_en     = 1'b0;
    pipe_stall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic seen_ready;

    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    div_en       = 1'b0;
    div_sign     = 1'b0;
    div_a        = '0;
    div_b        = '0;
    cancel       = 1'b0;
    pipe_stall   = 1'b0;

    vecs[0] = '{"u_100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"s_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2] = '{"s_ovf",        1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0};
    vecs[3] = '{"u_div0",       1'b0, 32'h1234,       32'h0,          32'hFFFFFFFF,   32'h1234};
    vecs[4] = '{"u_big",        1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1};
    vecs[5] = '{"s_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[6] = '{"s_m100_m7",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
    vecs[7] = '{"u_small",      1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
    vecs[8] = '{"s_div0",       1'b1, 32'hFFFFFFFB,   32'h0,          32'd1,          32'hFFFFFFFB};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", W'(div_ready), W'(0));
    checkOutput("rst_busy",  W'(div_busy),  W'(0));
    checkOutput("rst_hi",    div_hi,        W'(0));
    checkOutput("rst_lo",    div_lo,        W'(0));
    resetn = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].sign, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
      waitResult(vecs[i].name);
      releaseResult();
    end

    // Hold in DONE under stall; div_en stays high and must not restart.
    applyStimulus(1'b0, 32'd77, 32'd8, 32'd9, 32'd5);
    waitResult("hold_op");
    pipe_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_ready_%0d", k), W'(div_ready), W'(1));
      checkOutput($sformatf("hold_lo_%0d", k),    div_lo,        W'(9));
      checkOutput($sformatf("hold_hi_%0d", k),    div_hi,        W'(5));
    end
    pipe_stall = 1'b0;
    @(negedge clk);
    checkOutput("hold_exit_ready", W'(div_ready), W'(0));
    checkOutput("hold_exit_busy",  W'(div_busy),  W'(0));

    // Back-to-back: next DIVU issued in the very next IDLE cycle.
    applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    waitResult("b2b_op");
    releaseResult();

    // Cancel at BUSY iteration 10: no result, old hi/lo retained.
    div_en   = 1'b1;
    div_sign = 1'b0;
    div_a    = 32'd50;
    div_b    = 32'd5;
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    checkOutput("cancel_ready", W'(div_ready), W'(0));
    checkOutput("cancel_busy",  W'(div_busy),  W'(0));
    cancel = 1'b0;
    div_en = 1'b0;
    seen_ready = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (div_ready) seen_ready = 1'b1;
    end
    checkOutput("cancel_no_ready", W'(seen_ready), W'(0));
    checkOutput("cancel_keep_lo",  div_lo,         W'(333));
    checkOutput("cancel_keep_hi",  div_hi,         W'(1));

    applyStimulus(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
    waitResult("after_cancel");
    releaseResult();

    // Reset mid-BUSY clears everything on the next edge.
    div_en   = 1'b1;
    div_sign = 1'b0;
    div_a    = 32'd9;
    div_b    = 32'd2;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    div_en = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", W'(div_ready), W'(0));
    checkOutput("midrst_busy",  W'(div_busy),  W'(0));
    checkOutput("midrst_hi",    div_hi,        W'(0));
    checkOutput("midrst_lo",    div_lo,        W'(0));
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'hF);
    waitResult("after_reset");
    releaseResult();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
